// File: rtl/network_scheduler_if.sv
// Bus bundle between the network scheduler and its environment: run control,
// spike input channels, neuron-updater handshake and neuron/synapse SRAM control.
// Ports: master = driver/environment side, slave = scheduler side.
// Optional: NS_OUT_TIMESTAMP_EN adds out_time (network time stamped onto each out_valid).
interface network_scheduler_if #(
    parameter int NR_DEPTH = 16,
    parameter int SR_DEPTH = 16384,
    parameter int N_CH     = 4,
    parameter int TIME_W   = 16
);
    localparam int IW = $clog2(SR_DEPTH);
    localparam int NW = $clog2(NR_DEPTH);

    // run control
    logic                 start;
    logic [TIME_W-1:0]    max_steps;
    logic [TIME_W-1:0]    network_time;
    logic                 busy;
    logic                 done;

    // presynaptic spike channels, channel k at in_index[k*IW +: IW]
    logic [N_CH-1:0]      in_valid;
    logic [N_CH*IW-1:0]   in_index;
    logic [N_CH-1:0]      in_ready;

    // neuron updater handshake and postsynaptic spike output
    logic                 nr_spike;
    logic                 out_valid;
    logic [NW-1:0]        out_index;
`ifdef NS_OUT_TIMESTAMP_EN
    logic [TIME_W-1:0]    out_time;
`endif

    // SRAM / datapath control
    logic [NW-1:0]        c_neuron_index;
    logic [IW-1:0]        c_synapse_index;
    logic                 c_neuron_we;
    logic                 c_accumulate;

    modport master (
        output start, max_steps, in_valid, in_index, nr_spike,
        input  in_ready, out_valid, out_index,
`ifdef NS_OUT_TIMESTAMP_EN
               out_time,
`endif
               c_neuron_index, c_synapse_index, c_neuron_we, c_accumulate,
               network_time, busy, done
    );

    modport slave (
        input  start, max_steps, in_valid, in_index, nr_spike,
        output in_ready, out_valid, out_index,
`ifdef NS_OUT_TIMESTAMP_EN
               out_time,
`endif
               c_neuron_index, c_synapse_index, c_neuron_we, c_accumulate,
               network_time, busy, done
    );
endinterface

// File: rtl/network_scheduler.sv
// Purpose: time-multiplexed neuron scheduler; sweeps neurons for update, inserts
//          accumulate sweeps for queued presynaptic spikes, counts network time steps.
// Latency: all control outputs registered; out_valid one cycle after the sampled write cycle.
// Backpressure: in_ready is a round-robin grant gated by FIFO-not-full; the FIFO
//          drains only while busy, so a stalled run fills it and deasserts in_ready.
// Ports: clk, reset (async, active-high), bus (network_scheduler_if.slave).
// Optional: define NS_OUT_TIMESTAMP_EN to add bus.out_time with its register.
module network_scheduler #(
    parameter int NR_DEPTH   = 16,
    parameter int SR_DEPTH   = 16384,
    parameter int N_CH       = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIME_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    network_scheduler_if.slave   bus
);
    localparam int IW = $clog2(SR_DEPTH);
    localparam int NW = $clog2(NR_DEPTH);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_ACCUM  = 2'd2
    } state_t;

    // ---------------- state ----------------
    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [NW-1:0]      i_proc_q, i_proc_d;
    logic [NW-1:0]      i_accu_q, i_accu_d;
    logic [TIME_W-1:0]  max_steps_q, max_steps_d;
    logic [TIME_W-1:0]  network_time_q, network_time_d;

    // ---------------- registered outputs ----------------
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_valid_q, out_valid_d;
    logic [NW-1:0]      out_index_q, out_index_d;
    logic [NW-1:0]      c_neuron_index_q, c_neuron_index_d;
    logic [IW-1:0]      c_synapse_index_q, c_synapse_index_d;
    logic               c_neuron_we_q, c_neuron_we_d;
    logic               c_accumulate_q, c_accumulate_d;
`ifdef NS_OUT_TIMESTAMP_EN
    logic [TIME_W-1:0]  out_time_q, out_time_d;
`endif

    // ---------------- spike FIFO and arbiter ----------------
    logic [IW-1:0]      fifo_mem_q [FIFO_DEPTH];
    logic [IW-1:0]      fifo_mem_d [FIFO_DEPTH];
    logic [FW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FW:0]        count_q, count_d;
    logic [CW-1:0]      rr_ptr_q, rr_ptr_d;

    logic               fifo_full;
    logic               fifo_nempty;
    logic [IW-1:0]      fifo_head;
    logic               grant_vld;
    logic [CW-1:0]      grant_idx;
    int                 cand;
    logic               push;
    logic [IW-1:0]      push_dat;
    logic               pop;
    logic [N_CH-1:0]    in_ready_c;

    // helpers for the FSM
    logic [TIME_W-1:0]  time_inc;
    logic               run_end;

    assign fifo_full   = (count_q == (FW+1)'(FIFO_DEPTH));
    assign fifo_nempty = (count_q != '0);
    assign fifo_head   = fifo_mem_q[rd_ptr_q];

    // Round-robin search starting at rr_ptr_q; the first requesting channel wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = 0;
        for (int j = 0; j < N_CH; j++) begin
            cand = int'(rr_ptr_q) + j;
            if (cand >= N_CH) cand = cand - N_CH;
            if (!grant_vld && bus.in_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = CW'(cand);
            end
        end
    end

    // Fullness uses the registered count, so a same-cycle pop never frees a slot early.
    always_comb begin
        in_ready_c = '0;
        if (grant_vld && !fifo_full) in_ready_c[grant_idx] = 1'b1;
    end

    assign push     = grant_vld && !fifo_full;
    assign push_dat = bus.in_index[int'(grant_idx)*IW +: IW];

    // Pointer only moves past a channel that actually transferred.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            if (grant_idx == CW'(N_CH-1)) rr_ptr_d = '0;
            else                          rr_ptr_d = grant_idx + CW'(1);
        end
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d             = wr_ptr_q + FW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + FW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (FW+1)'(1);
            2'b01:   count_d = count_q - (FW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // ---------------- scheduler FSM ----------------
    always_comb begin
        state_d           = state_q;
        phase_d           = phase_q;
        i_proc_d          = i_proc_q;
        i_accu_d          = i_accu_q;
        max_steps_d       = max_steps_q;
        network_time_d    = network_time_q;
        c_synapse_index_d = c_synapse_index_q;
        out_valid_d       = 1'b0;
        out_index_d       = out_index_q;
`ifdef NS_OUT_TIMESTAMP_EN
        out_time_d        = out_time_q;
`endif
        done_d            = 1'b0;
        pop               = 1'b0;
        time_inc          = network_time_q + TIME_W'(1);
        run_end           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d        = S_UPDATE;
                    phase_d        = 1'b0;
                    i_proc_d       = '0;
                    network_time_d = '0;
                    max_steps_d    = bus.max_steps;
                end
            end

            S_UPDATE: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d     = 1'b0;
                    out_valid_d = bus.nr_spike;
                    out_index_d = i_proc_q;
`ifdef NS_OUT_TIMESTAMP_EN
                    out_time_d  = network_time_q;
`endif
                    // NR_DEPTH is a power of two, so this also wraps to 0 after the last neuron.
                    i_proc_d    = i_proc_q + NW'(1);
                    if (i_proc_q == NW'(NR_DEPTH-1)) begin
                        network_time_d = time_inc;
                        // max_steps = 0 naturally means a full wrap of the counter.
                        if (time_inc == max_steps_q) begin
                            run_end = 1'b1;
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    // i_proc_d already holds the resume point for after the accumulate sweep.
                    if (!run_end && fifo_nempty) begin
                        pop               = 1'b1;
                        state_d           = S_ACCUM;
                        i_accu_d          = '0;
                        c_synapse_index_d = fifo_head;
                    end
                end
            end

            S_ACCUM: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d  = 1'b0;
                    i_accu_d = i_accu_q + NW'(1);
                    if (i_accu_q == NW'(NR_DEPTH-1)) begin
                        if (fifo_nempty) begin
                            pop               = 1'b1;
                            c_synapse_index_d = fifo_head;
                        end else begin
                            state_d = S_UPDATE;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end
        endcase

        // Outputs are registered copies of the next state so they line up with it.
        busy_d         = (state_d != S_IDLE);
        c_neuron_we_d  = (state_d != S_IDLE) && phase_d;
        c_accumulate_d = (state_d == S_ACCUM);
        case (state_d)
            S_ACCUM:  c_neuron_index_d = i_accu_d;
            S_UPDATE: c_neuron_index_d = i_proc_d;
            default:  c_neuron_index_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= S_IDLE;
            phase_q           <= 1'b0;
            i_proc_q          <= '0;
            i_accu_q          <= '0;
            max_steps_q       <= '0;
            network_time_q    <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            out_valid_q       <= 1'b0;
            out_index_q       <= '0;
            c_neuron_index_q  <= '0;
            c_synapse_index_q <= '0;
            c_neuron_we_q     <= 1'b0;
            c_accumulate_q    <= 1'b0;
`ifdef NS_OUT_TIMESTAMP_EN
            out_time_q        <= '0;
`endif
            fifo_mem_q        <= '{default: '0};
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            rr_ptr_q          <= '0;
        end else begin
            state_q           <= state_d;
            phase_q           <= phase_d;
            i_proc_q          <= i_proc_d;
            i_accu_q          <= i_accu_d;
            max_steps_q       <= max_steps_d;
            network_time_q    <= network_time_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            out_valid_q       <= out_valid_d;
            out_index_q       <= out_index_d;
            c_neuron_index_q  <= c_neuron_index_d;
            c_synapse_index_q <= c_synapse_index_d;
            c_neuron_we_q     <= c_neuron_we_d;
            c_accumulate_q    <= c_accumulate_d;
`ifdef NS_OUT_TIMESTAMP_EN
            out_time_q        <= out_time_d;
`endif
            fifo_mem_q        <= fifo_mem_d;
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            rr_ptr_q          <= rr_ptr_d;
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.network_time    = network_time_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_index       = out_index_q;
    assign bus.c_neuron_index  = c_neuron_index_q;
    assign bus.c_synapse_index = c_synapse_index_q;
    assign bus.c_neuron_we     = c_neuron_we_q;
    assign bus.c_accumulate    = c_accumulate_q;
`ifdef NS_OUT_TIMESTAMP_EN
    assign bus.out_time        = out_time_q;
`endif

endmodule

// File: tb/tb_network_scheduler.sv
// Directed bench for network_scheduler: NR_DEPTH=4, N_CH=2, FIFO_DEPTH=4, IW=4, TIME_W=4.
module tb_network_scheduler;
    localparam int NR_DEPTH   = 4;
    localparam int SR_DEPTH   = 16;
    localparam int N_CH       = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int TIME_W     = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    network_scheduler_if #(.NR_DEPTH(NR_DEPTH), .SR_DEPTH(SR_DEPTH), .N_CH(N_CH), .TIME_W(TIME_W)) bus ();

    network_scheduler #(
        .NR_DEPTH(NR_DEPTH), .SR_DEPTH(SR_DEPTH), .N_CH(N_CH),
        .FIFO_DEPTH(FIFO_DEPTH), .TIME_W(TIME_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_busy;
        logic [3:0] sweep_syn [4];
        sweep_syn[0] = 4'd7; sweep_syn[1] = 4'd8; sweep_syn[2] = 4'd9; sweep_syn[3] = 4'd10;

        bus.start     = 1'b0;
        bus.max_steps = '0;
        bus.in_valid  = '0;
        bus.in_index  = '0;
        bus.nr_spike  = 1'b0;

        // ---- reset state ----
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we", 32'(bus.c_neuron_we), 0);
        chk("rst_acc", 32'(bus.c_accumulate), 0);
        chk("rst_idx", 32'(bus.c_neuron_index), 0);
        chk("rst_syn", 32'(bus.c_synapse_index), 0);
        chk("rst_time", 32'(bus.network_time), 0);
        chk("rst_outv", 32'(bus.out_valid), 0);
        chk("rst_rdy", 32'(bus.in_ready), 0);

        // ---- plain two-step run, no spikes ----
        bus.max_steps = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int n = 0; n < 4; n++)
                for (int ph = 0; ph < 2; ph++) begin
                    chk("run_busy", 32'(bus.busy), 1);
                    chk("run_we", 32'(bus.c_neuron_we), 32'(ph));
                    chk("run_idx", 32'(bus.c_neuron_index), 32'(n));
                    chk("run_acc", 32'(bus.c_accumulate), 0);
                    chk("run_time", 32'(bus.network_time), 32'(s));
                    tick();
                end
        chk("run_done", 32'(bus.done), 1);
        chk("run_idle", 32'(bus.busy), 0);
        chk("run_time_end", 32'(bus.network_time), 2);
        tick();
        chk("run_done_pulse", 32'(bus.done), 0);

        // ---- single spike during neuron 1 read, then nr_spike on neuron 3 write ----
        bus.max_steps = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();                        // n0 ph1
        tick();                        // n1 ph0
        bus.in_valid = 2'b01;
        bus.in_index = {4'd0, 4'd5};
        #1;
        chk("sp_rdy", 32'(bus.in_ready), 32'h1);
        tick();                        // n1 ph1
        bus.in_valid = 2'b00;
        chk("sp_n1w_idx", 32'(bus.c_neuron_index), 1);
        chk("sp_n1w_we", 32'(bus.c_neuron_we), 1);
        tick();
        for (int a = 0; a < 4; a++)
            for (int ph = 0; ph < 2; ph++) begin
                chk("acc_flag", 32'(bus.c_accumulate), 1);
                chk("acc_idx", 32'(bus.c_neuron_index), 32'(a));
                chk("acc_we", 32'(bus.c_neuron_we), 32'(ph));
                chk("acc_syn", 32'(bus.c_synapse_index), 5);
                chk("acc_outv", 32'(bus.out_valid), 0);
                bus.nr_spike = 1'b1;   // must be ignored during accumulate
                tick();
            end
        bus.nr_spike = 1'b0;
        chk("resume_outv", 32'(bus.out_valid), 0);
        chk("resume_acc", 32'(bus.c_accumulate), 0);
        chk("resume_idx", 32'(bus.c_neuron_index), 2);
        chk("resume_we", 32'(bus.c_neuron_we), 0);
        tick(); tick(); tick();        // n2 ph1, n3 ph0, n3 ph1
        chk("n3w_idx", 32'(bus.c_neuron_index), 3);
        bus.nr_spike = 1'b1;
        tick();
        bus.nr_spike = 1'b0;
        chk("out_valid", 32'(bus.out_valid), 1);
        chk("out_index", 32'(bus.out_index), 3);
`ifdef NS_OUT_TIMESTAMP_EN
        chk("out_time", 32'(bus.out_time), 0);
`endif
        chk("sp_done", 32'(bus.done), 1);
        chk("sp_time", 32'(bus.network_time), 1);
        tick();
        chk("out_valid_pulse", 32'(bus.out_valid), 0);
        chk("sp_done_pulse", 32'(bus.done), 0);

        // ---- round-robin fill in IDLE (last grant was ch0, so ch1 goes first) ----
        bus.in_valid = 2'b11;
        bus.in_index = {4'd7, 4'd3}; #1; chk("rr_g1", 32'(bus.in_ready), 32'h2); tick();
        bus.in_index = {4'd6, 4'd8}; #1; chk("rr_g0", 32'(bus.in_ready), 32'h1); tick();
        bus.in_index = {4'd9, 4'd4}; #1; chk("rr_g1b", 32'(bus.in_ready), 32'h2); tick();
        bus.in_index = {4'd2, 4'd10}; #1; chk("rr_g0b", 32'(bus.in_ready), 32'h1); tick();
        chk("full_rdy", 32'(bus.in_ready), 0);
        tick();
        chk("full_rdy_hold", 32'(bus.in_ready), 0);
        bus.in_valid = 2'b00;

        // ---- four queued spikes: back-to-back accumulate sweeps ----
        bus.max_steps = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("q_n0_acc", 32'(bus.c_accumulate), 0);
        tick();                        // n0 ph1, pops 7
        tick();
        for (int sw = 0; sw < 4; sw++)
            for (int a = 0; a < 4; a++)
                for (int ph = 0; ph < 2; ph++) begin
                    chk("q_acc", 32'(bus.c_accumulate), 1);
                    chk("q_syn", 32'(bus.c_synapse_index), 32'(sweep_syn[sw]));
                    chk("q_idx", 32'(bus.c_neuron_index), 32'(a));
                    chk("q_we", 32'(bus.c_neuron_we), 32'(ph));
                    tick();
                end
        chk("q_resume_acc", 32'(bus.c_accumulate), 0);
        chk("q_resume_idx", 32'(bus.c_neuron_index), 1);
        tick(); tick(); tick(); tick(); // n1 ph1, n2 ph0, n2 ph1, n3 ph0
        bus.in_valid = 2'b01;
        bus.in_index = {4'd0, 4'd11};
        #1;
        chk("q_push_rdy", 32'(bus.in_ready), 32'h1);
        tick();                        // n3 ph1, FIFO holds 11
        bus.in_valid = 2'b00;
        chk("q_n3w_idx", 32'(bus.c_neuron_index), 3);
        tick();                        // run ends, 11 retained
        chk("q_done", 32'(bus.done), 1);
        chk("q_idle", 32'(bus.busy), 0);
        chk("q_acc_idle", 32'(bus.c_accumulate), 0);

        // ---- retained entry plus two more, reset mid-accumulate ----
        bus.in_valid = 2'b01;
        bus.in_index = {4'd0, 4'd12}; #1; chk("r_rdy0", 32'(bus.in_ready), 32'h1); tick();
        bus.in_index = {4'd0, 4'd13}; #1; chk("r_rdy1", 32'(bus.in_ready), 32'h1); tick();
        bus.in_valid = 2'b00;
        bus.max_steps = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();                        // n0 ph1, pops 11
        tick();
        chk("r_acc", 32'(bus.c_accumulate), 1);
        chk("r_syn", 32'(bus.c_synapse_index), 11);
        tick(); tick();                // ACCUM n1 ph0
        chk("r_acc_idx", 32'(bus.c_neuron_index), 1);
        reset = 1'b1;
        #1;
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_done", 32'(bus.done), 0);
        chk("ar_acc", 32'(bus.c_accumulate), 0);
        chk("ar_we", 32'(bus.c_neuron_we), 0);
        chk("ar_idx", 32'(bus.c_neuron_index), 0);
        chk("ar_syn", 32'(bus.c_synapse_index), 0);
        chk("ar_time", 32'(bus.network_time), 0);
        chk("ar_outv", 32'(bus.out_valid), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_done_after", 32'(bus.done), 0);
        chk("ar_busy_after", 32'(bus.busy), 0);
        bus.max_steps = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();                        // n0 ph1, FIFO empty so no pop
        tick();
        chk("ar_empty_acc", 32'(bus.c_accumulate), 0);
        chk("ar_empty_idx", 32'(bus.c_neuron_index), 1);
        for (int k = 0; k < 6; k++) tick();
        chk("ar_run_done", 32'(bus.done), 1);
        chk("ar_run_time", 32'(bus.network_time), 1);

        // ---- max_steps = 0 runs a full 2^TIME_W steps ----
        bus.max_steps = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_busy = 0;
        while (bus.busy === 1'b1 && n_busy < 1000) begin
            n_busy++;
            tick();
        end
        chk("wrap_cycles", 32'(n_busy), 128);
        chk("wrap_done", 32'(bus.done), 1);
        chk("wrap_time", 32'(bus.network_time), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
